// File: rtl/bram_tdp.sv
// Single-clock true dual-port byte-writable RAM, DEPTH x DATA_WIDTH, per-port write mode.
// Latency: 1 cycle address-to-data; 2 cycles when BRAM_OUT_REG_EN is defined (extra output register).
// Backpressure: none; an operation is accepted on every cycle its port enable is high.
module bram_tdp #(
  parameter int                        ADDR_WIDTH   = 10,
  parameter int                        DATA_WIDTH   = 16,
  parameter string                     WRITE_MODE_A = "WRITE_FIRST",
  parameter string                     WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [DATA_WIDTH-1:0]     INIT_VAL     = 16'hFFFF,
  parameter logic [DATA_WIDTH-1:0]     SRVAL        = 16'h0000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ENA,
  input  logic [DATA_WIDTH/8-1:0]      WEA,
  input  logic [ADDR_WIDTH-1:0]        ADDRA,
  input  logic [DATA_WIDTH-1:0]        DIA,
  output logic [DATA_WIDTH-1:0]        DOA,
  input  logic                         ENB,
  input  logic [DATA_WIDTH/8-1:0]      WEB,
  input  logic [ADDR_WIDTH-1:0]        ADDRB,
  input  logic [DATA_WIDTH-1:0]        DIB,
  output logic [DATA_WIDTH-1:0]        DOB
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Write modes decoded once to a small code so the read path is a plain mux.
  localparam logic [1:0] MODE_WF = 2'd0;
  localparam logic [1:0] MODE_RF = 2'd1;
  localparam logic [1:0] MODE_NC = 2'd2;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

  // Storage and first-stage output latches carry their power-up values in the declaration.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: INIT_VAL};
  logic [DATA_WIDTH-1:0] doa_lat = SRVAL;
  logic [DATA_WIDTH-1:0] dob_lat = SRVAL;

  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;
  logic [DATA_WIDTH-1:0] doa_nxt;
  logic [DATA_WIDTH-1:0] dob_nxt;

  // Word as it will look after this port's own lane writes (other lanes keep old data).
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Pre-edge contents: both ports see the old word on any same-cycle collision.
  assign rd_a = mem[ADDRA];
  assign rd_b = mem[ADDRB];

  // Byte-lane writes; port A is applied after port B so it wins shared lanes. RST does not gate writes.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (ENB && WEB[i]) mem[ADDRB][8*i +: 8] <= DIB[8*i +: 8];
      if (ENA && WEA[i]) mem[ADDRA][8*i +: 8] <= DIA[8*i +: 8];
    end
  end

  // Port A next read value according to its write mode; disabled port holds.
  always_comb begin
    doa_nxt = doa_lat;
    if (ENA) begin
      if (WEA == '0) begin
        doa_nxt = rd_a;
      end else begin
        case (MODE_A)
          MODE_RF: doa_nxt = rd_a;
          MODE_NC: doa_nxt = doa_lat;
          default: doa_nxt = merge_lanes(rd_a, DIA, WEA);
        endcase
      end
    end
  end

  // Port B next read value according to its write mode; disabled port holds.
  always_comb begin
    dob_nxt = dob_lat;
    if (ENB) begin
      if (WEB == '0) begin
        dob_nxt = rd_b;
      end else begin
        case (MODE_B)
          MODE_RF: dob_nxt = rd_b;
          MODE_NC: dob_nxt = dob_lat;
          default: dob_nxt = merge_lanes(rd_b, DIB, WEB);
        endcase
      end
    end
  end

  // Latch stage: reset overrides the read path on both ports.
  always_ff @(posedge CLK) begin
    if (RST) begin
      doa_lat <= SRVAL;
      dob_lat <= SRVAL;
    end else begin
      doa_lat <= doa_nxt;
      dob_lat <= dob_nxt;
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] doa_reg = SRVAL;
  logic [DATA_WIDTH-1:0] dob_reg = SRVAL;

  // Optional output register: only delays the latch value, advancing with its port enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      doa_reg <= SRVAL;
      dob_reg <= SRVAL;
    end else begin
      if (ENA) doa_reg <= doa_lat;
      if (ENB) dob_reg <= dob_lat;
    end
  end

  assign DOA = doa_reg;
  assign DOB = dob_reg;
`else
  assign DOA = doa_lat;
  assign DOB = dob_lat;
`endif

endmodule

// File: tb/tb_bram_tdp.sv
// Directed bench: three RAMs share all inputs and differ only in port B write mode
// (0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE); port A is WRITE_FIRST on all of them.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_bram_tdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  wea;
  logic [9:0]  addra;
  logic [15:0] dia;
  logic        enb;
  logic [1:0]  web;
  logic [9:0]  addrb;
  logic [15:0] dib;
  logic [15:0] doa [3];
  logic [15:0] dob [3];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  bram_tdp #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST")) u_wf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[0]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[0])
  );

  bram_tdp #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST")) u_rf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[1]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[1])
  );

  bram_tdp #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE")) u_nc (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[2]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[2])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus on both ports, then step past the rising edge.
  task automatic step(input logic r,
                      input logic ea, input logic [1:0] wa, input logic [9:0] aa, input logic [15:0] da,
                      input logic eb, input logic [1:0] wb, input logic [9:0] ab, input logic [15:0] db);
    rst = r;
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b0; wea = 2'b00; addra = '0; dia = '0;
    enb = 1'b0; web = 2'b00; addrb = '0; dib = '0;
    #1;
    // Power-up output value, before any edge and with no reset.
    chk("pwrup_doa", doa[0], 16'h0000);
    chk("pwrup_dob", dob[0], 16'h0000);

    // Power-up memory contents on both ends of the array.
    step(0, 1, 2'b00, 10'h000, 16'h0000, 1, 2'b00, 10'h3FF, 16'h0000);
    chk("pwrup_rd_a", doa[0], 16'hFFFF);
    for (int k = 0; k < 3; k++) chk($sformatf("pwrup_rd_b%0d", k), dob[k], 16'hFFFF);

    // A writes 0x1234 @0x010 while B reads it: A sees new (WRITE_FIRST), B sees old.
    step(0, 1, 2'b11, 10'h010, 16'h1234, 1, 2'b00, 10'h010, 16'h0000);
    chk("wr_a_wf", doa[0], 16'h1234);
    chk("coll_rd_old", dob[0], 16'hFFFF);

    // Next cycle B reads it back; A disabled, so DOA holds.
    step(0, 0, 2'b00, 10'h000, 16'h0000, 1, 2'b00, 10'h010, 16'h0000);
    for (int k = 0; k < 3; k++) chk($sformatf("readback_b%0d", k), dob[k], 16'h1234);
    chk("doa_hold_en0", doa[0], 16'h1234);

    // B writes 0xABCD @0x020 low lane only; prior DOB is 0x1234.
    step(0, 0, 2'b00, 10'h000, 16'h0000, 1, 2'b01, 10'h020, 16'hABCD);
    chk("bytewr_wf", dob[0], 16'hFFCD);
    chk("bytewr_rf", dob[1], 16'hFFFF);
    chk("bytewr_nc", dob[2], 16'h1234);

    step(0, 0, 2'b00, 10'h000, 16'h0000, 1, 2'b00, 10'h020, 16'h0000);
    for (int k = 0; k < 3; k++) chk($sformatf("bytewr_rd%0d", k), dob[k], 16'hFFCD);

    // Both ports write 0x030 with full enables: A wins.
    step(0, 1, 2'b11, 10'h030, 16'h1111, 1, 2'b11, 10'h030, 16'h2222);
    chk("coll_a_wf", doa[0], 16'h1111);
    chk("coll_b_wf", dob[0], 16'h2222);
    chk("coll_b_rf", dob[1], 16'hFFFF);
    chk("coll_b_nc", dob[2], 16'hFFCD);

    // Partial overlap @0x031: A writes high lane only, B writes both lanes.
    step(0, 1, 2'b10, 10'h031, 16'h7766, 1, 2'b11, 10'h031, 16'h8899);
    chk("pcoll_a_wf", doa[0], 16'h77FF);

    step(0, 1, 2'b00, 10'h030, 16'h0000, 1, 2'b00, 10'h031, 16'h0000);
    chk("coll_result", doa[0], 16'h1111);
    for (int k = 0; k < 3; k++) chk($sformatf("pcoll_result%0d", k), dob[k], 16'h7799);

    // A writes 0x5555 @0x040 while B reads it: B gets the old word.
    step(0, 1, 2'b11, 10'h040, 16'h5555, 1, 2'b00, 10'h040, 16'h0000);
    chk("wr_rd_old", dob[1], 16'hFFFF);

    step(0, 1, 2'b00, 10'h010, 16'h0000, 1, 2'b00, 10'h040, 16'h0000);
    chk("wr_rd_new", dob[0], 16'h5555);
    chk("pre_rst_doa", doa[0], 16'h1234);

    // Reset clears outputs but not memory.
    step(1, 1, 2'b00, 10'h010, 16'h0000, 0, 2'b00, 10'h000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_doa%0d", k), doa[k], 16'h0000);
      chk($sformatf("rst_dob%0d", k), dob[k], 16'h0000);
    end

    step(0, 1, 2'b00, 10'h010, 16'h0000, 0, 2'b00, 10'h000, 16'h0000);
    chk("post_rst_mem", doa[0], 16'h1234);

    // Write during reset still lands in memory.
    step(1, 1, 2'b11, 10'h050, 16'h0BAD, 0, 2'b00, 10'h000, 16'h0000);
    chk("rst_wr_doa", doa[0], 16'h0000);
    step(0, 0, 2'b00, 10'h000, 16'h0000, 1, 2'b00, 10'h050, 16'h0000);
    chk("rst_wr_mem", dob[0], 16'h0BAD);

    // ENA=0 with write enables set: no write, DOA holds.
    step(0, 1, 2'b00, 10'h020, 16'h0000, 0, 2'b00, 10'h000, 16'h0000);
    chk("a_rd_020", doa[0], 16'hFFCD);
    step(0, 0, 2'b11, 10'h020, 16'hDEAD, 0, 2'b00, 10'h000, 16'h0000);
    chk("en0_doa_hold", doa[0], 16'hFFCD);
    chk("en0_dob_hold", dob[0], 16'h0BAD);
    step(0, 0, 2'b00, 10'h000, 16'h0000, 1, 2'b00, 10'h020, 16'h0000);
    chk("en0_no_write", dob[0], 16'hFFCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bram_tdp.md
# bram_tdp

Single-clock true dual-port block RAM: two independent read/write ports sharing one storage array of 1024 x 16 bits. It is the generic behavioural equivalent of the vendor TDP BRAM macro. It backs the dual-port register/buffer memories (e.g. the 256x16 DPRAM wrapper, which ties the upper address bits to 0).

## Interface
Parameters:
- ADDR_WIDTH, 10: address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16: word width; must be a multiple of 8.
- WRITE_MODE_A, "WRITE_FIRST": port A write mode; one of "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
- WRITE_MODE_B, "WRITE_FIRST": port B write mode; same choices as port A.
- INIT_VAL, 16'hFFFF: power-up value of every memory word.
- SRVAL, 16'h0000: value loaded into DOA/DOB on reset.

Ports:
- CLK  input  1  single clock for both ports; rising edge.
- RST  input  1  reset; synchronous, active-high.
- ENA  input  1  port A enable; when low, port A neither reads nor writes.
- WEA  input  DATA_WIDTH/8  port A byte write enables; bit i covers DIA[8i+7:8i].
- ADDRA  input  ADDR_WIDTH  port A address.
- DIA  input  DATA_WIDTH  port A write data.
- DOA  output  DATA_WIDTH  port A read data.
- ENB, WEB, ADDRB, DIB, DOB: port B equivalents of the port A signals.

## Operation
- Memory words initialise to INIT_VAL. RST never alters memory contents.
- Port X is processed on each rising edge where ENX=1:
  - Each byte lane with WEX[i]=1 is written from DIX at ADDRX.
  - Lanes with WEX[i]=0 keep their contents.
- DOX update, per WRITE_MODE_X:
  - No write (WEX all 0), any mode: DOX <= mem[ADDRX].
  - WRITE_FIRST with a write: DOX shows the merged new word (written lanes come from DIX, others keep their old value).
  - READ_FIRST with a write: DOX shows the old word.
  - NO_CHANGE with a write: DOX holds its previous value.
- ENX=0: DOX holds its value and memory is untouched.
- RST=1: DOA and DOB load SRVAL on that edge. Reset overrides the read path, but writes enabled in the same cycle are still performed.
- Both ports writing the same address in the same cycle:
  - Port A wins on each lane both ports write.
  - A lane written only by port B still takes port B's data.
- One port writing an address while the other port reads it in the same cycle: the reader gets the old word.
- Address is always in range. No wrap logic is needed beyond ADDR_WIDTH truncation.

## Timing
- Read latency is 1 cycle: ADDRX is sampled at edge N and the data appears on DOX after edge N.
- A write is visible to the other port's read from edge N+1 onwards.
- Reset takes effect on the edge where RST is sampled high; DOA=DOB=SRVAL after that edge.
- Power-up value of DOA/DOB is SRVAL.
- No handshake: the block accepts an operation on every enabled cycle, back to back.

## Configuration
- BRAM_OUT_REG_EN defined:
  - Adds one output register stage per port, so read latency becomes 2 cycles.
  - Each stage advances only when its port's EN=1.
  - RST clears both the latch stage and the register stage to SRVAL.
  - WRITE_MODE semantics apply at the latch stage; the register stage only delays that value.
- BRAM_OUT_REG_EN not defined: latency is 1 cycle, as above.

## Test plan
- Power-up read: with no reset, read A=0x000 and B=0x3FF -> DOA=DOB=0xFFFF one cycle later.
- Write/readback: port A writes 0x1234 at 0x010 with WEA=2'b11; the next cycle port B reads 0x010 -> DOB=0x1234. In WRITE_FIRST, DOA=0x1234 in the write cycle.
- Byte enables and modes, on a word holding 0xFFFF at 0x020:
  - Port B writes 0xABCD at 0x020 with WEB=2'b01 -> the word becomes 0xFFCD.
  - In the write cycle, DOB=0xFFCD for WRITE_FIRST, 0xFFFF for READ_FIRST, and its prior value for NO_CHANGE.
- Collision:
  - Same cycle: port A writes 0x1111 and port B writes 0x2222, both at 0x030 with full enables -> a later read returns 0x1111.
  - A writes 0x5555 at 0x040 while B reads 0x040 -> DOB shows the old word.
- Reset/enable:
  - After DOA=0x1234, assert RST for one cycle -> DOA=DOB=0x0000, and memory still reads back 0x1234.
  - With ENA=0 and WEA=2'b11, memory is unchanged and DOA holds its value.
- BRAM_OUT_REG_EN: the readback scenario above yields the data 2 cycles after the address is applied.
